// File: rtl/rom_io_responder_pkg.sv
// Shared types and opcode constants for the ROM + I/O bus responder.
package rom_io_responder_pkg;

  typedef enum logic [3:0] {
    PH_IDLE, PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
  } phase_e;

  typedef enum logic [1:0] {
    IO_NONE, IO_WRR, IO_RDR
  } io_op_e;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  function automatic io_op_e decode_io(input logic [3:0] opa);
    case (opa)
      OPA_WRR: return IO_WRR;
      OPA_RDR: return IO_RDR;
      default: return IO_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rom_io_responder_if.sv
// CPU instruction-bus signals as seen between the CPU (master) and a ROM chip (slave).
interface rom_io_responder_if;
  logic       sync;
  logic       rom_cmd;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;

  modport master (output sync, rom_cmd, data_i, input data_o, data_en);
  modport slave  (input sync, rom_cmd, data_i, output data_o, data_en);
endinterface

// File: rtl/rom_io_responder_bus_phase_tracker.sv
// Follows the 8-phase bus cycle; sync forces A1 on the next edge from any phase.
module rom_io_responder_bus_phase_tracker
  import rom_io_responder_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   sync,
  output phase_e phase,
  output phase_e next_phase
);

  // NOTE: every path through always_comb assigns next_phase first, so no latch is inferred.
  always_comb begin
    next_phase = PH_IDLE;
    if (sync) begin
      next_phase = PH_A1;
    end else begin
      case (phase)
        PH_A1:   next_phase = PH_A2;
        PH_A2:   next_phase = PH_A3;
        PH_A3:   next_phase = PH_M1;
        PH_M1:   next_phase = PH_M2;
        PH_M2:   next_phase = PH_X1;
        PH_X1:   next_phase = PH_X2;
        PH_X2:   next_phase = PH_X3;
        default: next_phase = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) phase <= PH_IDLE;
    else          phase <= next_phase;
  end

endmodule

// File: rtl/rom_io_responder.sv
// 4001-style ROM + I/O chip: returns opcode nibbles in M1/M2 and handles SRC, WRR and RDR.
module rom_io_responder
  import rom_io_responder_pkg::*;
#(
  parameter logic [3:0] CHIP_ID  = 4'h0,
  parameter logic [3:0] IO_RESET = 4'h0
) (
  input  logic               clock,
  input  logic               reset_n,
  rom_io_responder_if.slave  bus,
  input  logic [3:0]         io_in,
  output logic [3:0]         io_out,
  input  logic               prog_we,
  input  logic [7:0]         prog_addr,
  input  logic [7:0]         prog_data
);

  phase_e     phase;
  phase_e     next_phase;
  logic [7:0] addr;
  logic [3:0] opa;
  logic       hit;
  logic       src_sel;
  io_op_e     io_op;
  logic [7:0] mem [256];

  logic       chip_match;
  logic [7:0] fetch_byte;

  assign chip_match = (bus.data_i == CHIP_ID);
  assign fetch_byte = mem[addr];

  rom_io_responder_bus_phase_tracker u_phase (
    .clock      (clock),
    .reset_n    (reset_n),
    .sync       (bus.sync),
    .phase      (phase),
    .next_phase (next_phase)
  );

  // NOTE: the program store has no reset; its contents survive reset and are loaded via prog_we.
  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      opa         <= '0;
      hit         <= 1'b0;
      src_sel     <= 1'b0;
      io_op       <= IO_NONE;
      io_out      <= IO_RESET;
      bus.data_o  <= '0;
      bus.data_en <= 1'b0;
    end else begin
      // A resync abandons the partial cycle: only the A1 clear of io_op happens.
      if (bus.sync) begin
        io_op <= IO_NONE;
      end else begin
        case (phase)
          PH_A1: addr[3:0] <= bus.data_i;
          PH_A2: addr[7:4] <= bus.data_i;
          PH_A3: begin
            hit <= chip_match;
            opa <= fetch_byte[3:0];
          end
          PH_M2: if (bus.rom_cmd && hit) io_op <= decode_io(opa);
          PH_X2: begin
            // NOTE: non-blocking updates mean the WRR test below sees src_sel from before this edge.
            if (bus.rom_cmd) src_sel <= chip_match;
            if (io_op == IO_WRR && src_sel) io_out <= bus.data_i;
          end
          default: ;
        endcase
      end

      bus.data_en <= 1'b0;
      bus.data_o  <= '0;
      case (next_phase)
        PH_M1: if (chip_match) begin
          bus.data_en <= 1'b1;
          bus.data_o  <= fetch_byte[7:4];
        end
        PH_M2: if (hit) begin
          bus.data_en <= 1'b1;
          bus.data_o  <= opa;
        end
        PH_X2: if (io_op == IO_RDR && src_sel) begin
          bus.data_en <= 1'b1;
          bus.data_o  <= io_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_io_responder.sv
// Directed bench for rom_io_responder: fetch hit/miss, SRC/WRR/RDR, resync, store write, reset.
module tb_rom_io_responder;
  import rom_io_responder_pkg::*;

  localparam logic [3:0] CHIP     = 4'h0;
  localparam logic [3:0] IO_RST_V = 4'h5;

  logic       clk;
  logic       rst_n;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_data;

  rom_io_responder_if bus ();

  rom_io_responder #(.CHIP_ID(CHIP), .IO_RESET(IO_RST_V)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .bus       (bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       m1_en, m2_en, x1_en, x2_en, x3_en;
  logic [3:0] m1_d, m2_d, x2_d;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one phase's inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic s, input logic cmd, input logic [3:0] d);
    @(negedge clk);
    bus.sync    = s;
    bus.rom_cmd = cmd;
    bus.data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
  endtask

  // One full bus cycle; ends in X3 so the next call's sync step is a proper X3 sync.
  task automatic run_cycle(input logic [7:0] a, input logic [3:0] chip,
                           input logic m2_cmd, input logic x2_cmd, input logic [3:0] x2_data);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, a[3:0]);
    step(1'b0, 1'b0, a[7:4]);
    step(1'b0, 1'b0, chip);
    m1_en = bus.data_en; m1_d = bus.data_o;
    step(1'b0, 1'b0, 4'h0);
    m2_en = bus.data_en; m2_d = bus.data_o;
    step(1'b0, m2_cmd, 4'h0);
    x1_en = bus.data_en;
    step(1'b0, 1'b0, 4'h0);
    x2_en = bus.data_en; x2_d = bus.data_o;
    step(1'b0, x2_cmd, x2_data);
    x3_en = bus.data_en;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sync = 1'b0; bus.rom_cmd = 1'b0; bus.data_i = 4'h0;
    io_in = 4'h0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    prog(8'h25, 8'hD7);
    prog(8'h10, {OPR_IO, OPA_WRR});
    prog(8'h30, {OPR_IO, OPA_RDR});
    check("reset_data_en", bus.data_en, 1'b0);
    check("reset_data_o",  bus.data_o,  4'h0);
    check("reset_io_out",  io_out,      IO_RST_V);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'h0);
      check("idle_no_drive", bus.data_en, 1'b0);
    end

    // Fetch hit
    run_cycle(8'h25, CHIP, 1'b0, 1'b0, 4'h0);
    check("hit_m1_en", m1_en, 1'b1);
    check("hit_m1_d",  m1_d,  4'hD);
    check("hit_m2_en", m2_en, 1'b1);
    check("hit_m2_d",  m2_d,  4'h7);
    check("hit_x_en",  {x1_en, x2_en, x3_en}, 3'b000);

    // Fetch miss
    run_cycle(8'h25, 4'h1, 1'b0, 1'b0, 4'h0);
    check("miss_en", {m1_en, m2_en, x1_en, x2_en, x3_en}, 5'b0);
    check("miss_d",  {m1_d, m2_d}, 8'h00);

    // SRC select then WRR
    run_cycle(8'h25, CHIP, 1'b0, 1'b1, CHIP);
    run_cycle(8'h10, CHIP, 1'b1, 1'b0, 4'h9);
    check("wrr_io_out", io_out, 4'h9);
    check("wrr_x2_en",  x2_en, 1'b0);

    // WRR fetched by another chip is ignored
    run_cycle(8'h10, 4'h1, 1'b1, 1'b0, 4'h4);
    check("miss_wrr_io_out", io_out, 4'h9);

    // SRC of another chip deselects
    run_cycle(8'h25, CHIP, 1'b0, 1'b1, 4'h3);
    run_cycle(8'h10, CHIP, 1'b1, 1'b0, 4'h7);
    check("desel_wrr_io_out", io_out, 4'h9);

    // RDR
    run_cycle(8'h25, CHIP, 1'b0, 1'b1, CHIP);
    io_in = 4'h6;
    run_cycle(8'h30, CHIP, 1'b1, 1'b0, 4'h0);
    check("rdr_x2_en",  x2_en, 1'b1);
    check("rdr_x2_d",   x2_d,  4'h6);
    check("rdr_x1_en",  x1_en, 1'b0);
    check("rdr_x3_en",  x3_en, 1'b0);
    check("rdr_io_out", io_out, 4'h9);

    // SRC and WRR on the same X2 edge: WRR sees the old (deselected) src_sel
    run_cycle(8'h25, CHIP, 1'b0, 1'b1, 4'h3);
    run_cycle(8'h10, CHIP, 1'b1, 1'b1, CHIP);
    check("same_edge_io_out", io_out, 4'h9);
    run_cycle(8'h10, CHIP, 1'b1, 1'b0, 4'hB);
    check("after_src_io_out", io_out, 4'hB);

    // Resync during M1
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b0, 4'h2);
    step(1'b0, 1'b0, CHIP);
    check("resync_pre_m1_en", bus.data_en, 1'b1);
    step(1'b1, 1'b0, 4'h0);
    check("resync_en", bus.data_en, 1'b0);
    check("resync_d",  bus.data_o,  4'h0);
    run_cycle(8'h25, CHIP, 1'b0, 1'b0, 4'h0);
    check("post_resync_m1", {m1_en, m1_d}, {1'b1, 4'hD});
    check("post_resync_m2", {m2_en, m2_d}, {1'b1, 4'h7});

    // Store write coinciding with the A3 fetch edge
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b0, 4'h2);
    prog_we = 1'b1; prog_addr = 8'h25; prog_data = 8'h3C;
    step(1'b0, 1'b0, CHIP);
    prog_we = 1'b0;
    check("wr_fetch_old_m1", bus.data_o, 4'hD);
    step(1'b0, 1'b0, 4'h0);
    check("wr_fetch_old_m2", bus.data_o, 4'h7);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    run_cycle(8'h25, CHIP, 1'b0, 1'b0, 4'h0);
    check("wr_fetch_new", {m1_d, m2_d}, 8'h3C);

    // Asynchronous reset in the middle of M1
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h5);
    step(1'b0, 1'b0, 4'h2);
    step(1'b0, 1'b0, CHIP);
    check("pre_rst_m1_en", bus.data_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_data_en", bus.data_en, 1'b0);
    check("mid_rst_data_o",  bus.data_o,  4'h0);
    check("mid_rst_io_out",  io_out,      IO_RST_V);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, CHIP);
      check("post_rst_idle", bus.data_en, 1'b0);
    end
    run_cycle(8'h25, CHIP, 1'b0, 1'b0, 4'h0);
    check("post_rst_fetch", {m1_en, m1_d, m2_en, m2_d}, {1'b1, 4'h3, 1'b1, 4'hC});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_io_responder.md
Name: rom_io_responder

Overview:
Bus-side responder for the 4-bit CPU's instruction bus. It is the 4001-style ROM-plus-I/O chip that answers the CPU's sync/rom_cmd bus cycles. It tracks the 8-phase bus cycle and decodes the 12-bit fetch address. When its chip number matches, it returns the opcode byte from an internal 256x8 program store, one nibble in each of M1 and M2. It also implements SRC chip select and the WRR/RDR I/O port instructions.

Parameters:
CHIP_ID, 4'h0, chip number matched against the A3 nibble and the SRC chip nibble
IO_RESET, 4'h0, value loaded into io_out on reset

Ports:
clock  input  1  single system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
sync  input  1  CPU sync; high during X3, so the next cycle is A1
rom_cmd  input  1  CPU ROM command line (CM-ROM)
data_i  input  4  nibble driven by the CPU (CPU data_o)
data_o  output  4  nibble driven to the CPU (CPU data_i)
data_en  output  1  high while this block drives data_o
io_in  input  4  external I/O port input, read by RDR
io_out  output  4  external I/O port output latch, written by WRR
prog_we  input  1  program-store write enable
prog_addr  input  8  program-store write address
prog_data  input  8  program-store write data

Behaviour:
- Reset (async, reset_n=0): phase register=IDLE; data_o=0; data_en=0; io_out=IO_RESET; src_sel=0; hit=0; io_op=NONE. Program store contents are not reset.
- Phases: IDLE, A1, A2, A3, M1, M2, X1, X2, X3, held in a one-hot or 4-bit register.
- Phase transitions at each rising edge:
  - sync=1: next phase is A1 from any phase, including mid-cycle (resync).
  - sync=0: A1->A2->A3->M1->M2->X1->X2->X3->IDLE, and IDLE->IDLE.
- Address capture, sampling data_i at the edge that ends each phase:
  - A1 -> addr[3:0]
  - A2 -> addr[7:4]
  - A3 -> hit <= (data_i==CHIP_ID); opcode <= mem[addr], where addr is built from the A1 and A2 nibbles.
- Opcode drive. data_o and data_en are registered and change on the same edge as the phase register:
  - During M1: data_en=hit, data_o=opcode[7:4].
  - During M2: data_en=hit, data_o=opcode[3:0].
  - data_en=0 in every other phase except an RDR X2. data_o=0 whenever data_en=0.
- I/O decode:
  - At the edge ending M2, if rom_cmd=1 and hit=1: io_op <= WRR when opcode[3:0]==4'h2, RDR when 4'hA, otherwise NONE.
  - io_op is cleared at A1.
  - Decided simplification: I/O instructions are only honoured when this block fetched the instruction (hit=1).
- SRC: at the edge ending X2, if rom_cmd=1, then src_sel <= (data_i==CHIP_ID). rom_cmd at X2 marks SRC; rom_cmd at M2 marks an I/O op. The two are independent.
- WRR: at the edge ending X2, if io_op==WRR and src_sel=1, then io_out <= data_i.
- RDR: during X2, if io_op==RDR and src_sel=1, data_en=1 and data_o=io_in. io_in is sampled at the edge entering X2.
- SRC and WRR on the same X2 edge: WRR uses the old src_sel value.
- Program store:
  - prog_we writes mem[prog_addr]<=prog_data synchronously, at any time.
  - A write and the A3 fetch to the same address on the same edge: the fetch returns the old byte.
- Resync while driving (sync=1 during M1/M2/X2): data_en drops to 0 at that edge. The partial cycle has no side effects except address nibbles already captured.
- Reset mid-operation: data_en falls immediately (async); io_out returns to IO_RESET.

Decomposition:
- Shared package: phase enum (IDLE, A1..X3); io_op enum (NONE, WRR, RDR); opcode constants OPR_IO=4'hE, OPA_WRR=4'h2, OPA_RDR=4'hA.
- One natural sub-module, bus_phase_tracker. It takes sync and produces the current phase and next phase, which the data path uses for the registered outputs.

Test Plan:
- Reset: assert reset_n=0 mid-M1 with data_en=1 -> data_en=0 and data_o=0 immediately, io_out=IO_RESET; after release the phase stays IDLE until sync.
- Fetch hit: mem[8'h25]=8'hD7, CHIP_ID=0, sync then data_i 5,2,0 in A1..A3 -> M1: data_en=1, data_o=D; M2: data_en=1, data_o=7; X1..X3: data_en=0.
- Fetch miss: same cycle with A3 nibble=1 -> data_en=0 for the whole cycle; a later SRC/WRR has no effect on io_out.
- WRR:
  - Stimulus: SRC cycle with rom_cmd=1 in X2, data_i=0; then fetch mem[8'h10]=8'hE2 with rom_cmd=1 in M2, data_i=9 in X2.
  - Response: io_out=9 after X2.
  - Repeat with SRC data_i=3 -> io_out unchanged.
- RDR: src_sel=1, fetch 8'hEA with rom_cmd=1 in M2, io_in=6 -> during X2 data_en=1 and data_o=6; io_out unchanged.
- Resync and store write:
  - sync pulsed during M1 -> next phase A1 and data_en=0; the following full cycle fetches correctly.
  - prog_we to 8'h25 on the A3 edge of a fetch of 8'h25 -> old byte returned; the next fetch returns the new byte.
